maze_dfs_ctrl: RTL and testbench

- Parametrised depth-first maze solver controller for an R x C grid held in an external 1-bit map RAM (1 = wall or visited, 0 = free).
- Searches from cell (0,0) to cell (C-1,R-1) by probing neighbours and recording the path in an internal LIFO.
- Backtracks at dead ends, resuming at the next untried direction of each popped cell.
- On request, replays the found path as a stream of move directions to the downstream motion/display logic.

---
 rtl/maze_pkg.sv | 30 +++
 rtl/maze_dfs_ctrl_stack.sv | 53 +++++
 rtl/maze_dfs_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_maze_dfs_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze solver: move directions and controller states.
package maze_pkg;

    localparam int DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_CHECK,
        ST_PROBE,
        ST_WAIT,
        ST_BACKTRACK,
        ST_DONE,
        ST_REPLAY,
        ST_FAIL
    } state_t;

    // Direction counter runs 0..4; the extra value means "all four tried".
    function automatic logic [DIR_W:0] nextDir(input logic [DIR_W:0] d);
        return d + 3'd1;
    endfunction

endpackage

// File: rtl/maze_dfs_ctrl_stack.sv
// Path LIFO for the maze solver: push/pop/clear plus an indexed read for replay.
module path_stack #(
    parameter int W        = 6,
    parameter int RW       = 2,
    parameter int DEPTH    = 256,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  pushData,
    input  logic          pop,
    output logic [W-1:0]  topData,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    input  logic [IW-1:0] rdIdx,
    output logic [RW-1:0] rdData
);

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] countReg;
    logic [IW-1:0] topIdx;

    assign full    = (countReg == CW'(DEPTH));
    assign empty   = (countReg == '0);
    assign count   = countReg;
    assign topIdx  = IW'(countReg - CW'(1));
    assign topData = mem[topIdx];
    // Replay only needs the low field of each entry (the move direction).
    assign rdData  = mem[rdIdx][RW-1:0];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[countReg[IW-1:0]] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (push && !full) begin
            countReg <= countReg + CW'(1);
        end else if (pop && !empty) begin
            countReg <= countReg - CW'(1);
        end
    end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze solver: walks an external 1-bit map from (0,0) to the far
// corner, keeps the path on a LIFO and can replay it as a direction stream.
module maze_dfs_ctrl
    import maze_pkg::*;
#(
    parameter int X_W   = 4,
    parameter int Y_W   = 4,
    parameter int DEPTH = 256,
    localparam int A_W  = X_W + Y_W,
    localparam int PL_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            run,
    output logic [A_W-1:0]  map_addr,
    output logic            map_rd,
    input  logic            map_rdata,
    output logic            map_wr,
    output logic            map_wdata,
    output logic [A_W-1:0]  cur_loc,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic            overflow,
    output logic [PL_W-1:0] path_len,
    output logic            move_valid,
    output logic [1:0]      move_dir,
    output logic            path_end
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry width follows the grid parameters, so the struct lives here.
    typedef struct packed {
        logic [A_W-1:0] loc;
        dir_t           dir;
    } stackEntry_t;

    state_t          stateReg, stateNext;
    logic [A_W-1:0]  curLocReg, curLocNext;
    logic [DIR_W:0]  dirReg, dirNext;
    logic            overflowReg, overflowNext;
    logic [PL_W-1:0] replayIdxReg, replayIdxNext;

    logic [X_W-1:0]  xPos;
    logic [Y_W-1:0]  yPos;
    logic            inBounds;
    logic [A_W-1:0]  nbrAddr;

    logic            stackClear, stackPush, stackPop;
    logic            stackFull, stackEmpty;
    logic [PL_W-1:0] stackCount;
    stackEntry_t     pushEntry, topEntry;
    logic [1:0]      replayDir;

    assign xPos      = curLocReg[X_W-1:0];
    assign yPos      = curLocReg[A_W-1:X_W];
    assign pushEntry = '{loc: curLocReg, dir: dir_t'(dirReg[DIR_W-1:0])};

    // Bounds are judged on the unwrapped coordinate before forming the address.
    always_comb begin
        inBounds = 1'b0;
        nbrAddr  = curLocReg;
        case (dir_t'(dirReg[DIR_W-1:0]))
            DIR_UP: begin
                inBounds = (yPos != '0);
                nbrAddr  = {yPos - Y_W'(1), xPos};
            end
            DIR_RIGHT: begin
                inBounds = (xPos != '1);
                nbrAddr  = {yPos, xPos + X_W'(1)};
            end
            DIR_DOWN: begin
                inBounds = (yPos != '1);
                nbrAddr  = {yPos + Y_W'(1), xPos};
            end
            DIR_LEFT: begin
                inBounds = (xPos != '0);
                nbrAddr  = {yPos, xPos - X_W'(1)};
            end
            default: ;
        endcase
    end

    path_stack #(
        .W     ($bits(stackEntry_t)),
        .RW    (DIR_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (stackClear),
        .push     (stackPush),
        .pushData (pushEntry),
        .pop      (stackPop),
        .topData  (topEntry),
        .full     (stackFull),
        .empty    (stackEmpty),
        .count    (stackCount),
        .rdIdx    (replayIdxReg[IW-1:0]),
        .rdData   (replayDir)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curLocReg    <= '0;
            dirReg       <= '0;
            overflowReg  <= 1'b0;
            replayIdxReg <= '0;
        end else begin
            curLocReg    <= curLocNext;
            dirReg       <= dirNext;
            overflowReg  <= overflowNext;
            replayIdxReg <= replayIdxNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        curLocNext    = curLocReg;
        dirNext       = dirReg;
        overflowNext  = overflowReg;
        replayIdxNext = replayIdxReg;
        case (stateReg)
            ST_IDLE, ST_FAIL: begin
                if (start) stateNext = ST_INIT;
            end
            ST_INIT: begin
                curLocNext   = '0;
                dirNext      = '0;
                overflowNext = 1'b0;
                stateNext    = ST_CHECK;
            end
            ST_CHECK: begin
                stateNext = (&curLocReg) ? ST_DONE : ST_PROBE;
            end
            ST_PROBE: begin
                if (dirReg[DIR_W]) begin
                    stateNext = ST_BACKTRACK;
                end else if (!inBounds) begin
                    dirNext = nextDir(dirReg);
                end else begin
                    stateNext = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (map_rdata) begin
                    dirNext   = nextDir(dirReg);
                    stateNext = ST_PROBE;
                end else if (stackFull) begin
                    overflowNext = 1'b1;
                    stateNext    = ST_FAIL;
                end else begin
                    curLocNext = nbrAddr;
                    dirNext    = '0;
                    stateNext  = ST_CHECK;
                end
            end
            ST_BACKTRACK: begin
                if (stackEmpty) begin
                    stateNext = ST_FAIL;
                end else begin
                    curLocNext = topEntry.loc;
                    dirNext    = nextDir({1'b0, topEntry.dir});
                    stateNext  = ST_PROBE;
                end
            end
            ST_DONE: begin
                if (run) begin
                    replayIdxNext = '0;
                    stateNext     = ST_REPLAY;
                end else if (start) begin
                    stateNext = ST_INIT;
                end
            end
            ST_REPLAY: begin
                if (replayIdxReg == stackCount) begin
                    stateNext = ST_DONE;
                end else begin
                    replayIdxNext = replayIdxReg + PL_W'(1);
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        map_addr   = nbrAddr;
        map_rd     = 1'b0;
        map_wr     = 1'b0;
        map_wdata  = 1'b1;
        stackClear = 1'b0;
        stackPush  = 1'b0;
        stackPop   = 1'b0;
        move_valid = 1'b0;
        path_end   = 1'b0;
        case (stateReg)
            ST_INIT: begin
                map_addr   = '0;
                map_wr     = 1'b1;
                stackClear = 1'b1;
            end
            ST_PROBE: map_rd = !dirReg[DIR_W] && inBounds;
            ST_WAIT: begin
                map_wr    = !map_rdata && !stackFull;
                stackPush = !map_rdata && !stackFull;
            end
            ST_BACKTRACK: stackPop = !stackEmpty;
            ST_REPLAY: begin
                move_valid = (replayIdxReg != stackCount);
                path_end   = (replayIdxReg == stackCount);
            end
            default: ;
        endcase
    end

    assign move_dir = replayDir;
    assign cur_loc  = curLocReg;
    assign path_len = stackCount;
    assign overflow = overflowReg;
    assign done     = (stateReg == ST_DONE);
    assign fail     = (stateReg == ST_FAIL);
    assign busy     = !(stateReg inside {ST_IDLE, ST_DONE, ST_FAIL});

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// Randomised bench for maze_dfs_ctrl on a 4x4 grid: a queue-based DFS model
// feeds a scoreboard that a monitor drains on search completion and replay.
module tb_maze_dfs_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, startA, runA, startB, runB, loadA, loadB;
    logic [15:0] mapA, mapB, mapInitA, mapInitB;

    logic [3:0] mapAddrA, curLocA;
    logic       mapRdA, mapWrA, mapWdataA, busyA, doneA, failA, ovfA;
    logic       mapRdataA = 1'b0;
    logic [8:0] pathLenA;
    logic       moveValidA, pathEndA;
    logic [1:0] moveDirA;

    logic [3:0] mapAddrB, curLocB;
    logic       mapRdB, mapWrB, mapWdataB, busyB, doneB, failB, ovfB;
    logic       mapRdataB = 1'b0;
    logic [1:0] pathLenB;
    logic       moveValidB, pathEndB;
    logic [1:0] moveDirB;

    maze_dfs_ctrl #(.X_W(2), .Y_W(2), .DEPTH(256)) dutA (
        .clk(clk), .rst(rst), .start(startA), .run(runA),
        .map_addr(mapAddrA), .map_rd(mapRdA), .map_rdata(mapRdataA),
        .map_wr(mapWrA), .map_wdata(mapWdataA), .cur_loc(curLocA),
        .busy(busyA), .done(doneA), .fail(failA), .overflow(ovfA),
        .path_len(pathLenA), .move_valid(moveValidA), .move_dir(moveDirA),
        .path_end(pathEndA)
    );

    maze_dfs_ctrl #(.X_W(2), .Y_W(2), .DEPTH(3)) dutB (
        .clk(clk), .rst(rst), .start(startB), .run(runB),
        .map_addr(mapAddrB), .map_rd(mapRdB), .map_rdata(mapRdataB),
        .map_wr(mapWrB), .map_wdata(mapWdataB), .cur_loc(curLocB),
        .busy(busyB), .done(doneB), .fail(failB), .overflow(ovfB),
        .path_len(pathLenB), .move_valid(moveValidB), .move_dir(moveDirB),
        .path_end(pathEndB)
    );

    // Map RAMs: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (loadA) mapA <= mapInitA;
        else if (mapWrA) mapA[mapAddrA] <= mapWdataA;
        if (mapRdA) mapRdataA <= mapA[mapAddrA];
        if (loadB) mapB <= mapInitB;
        else if (mapWrB) mapB[mapAddrB] <= mapWdataB;
        if (mapRdB) mapRdataB <= mapB[mapAddrB];
    end

    int tests = 0;
    int fails = 0;
    int rdwrViol = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outcomeOf(input logic d, input logic f, input logic o);
        if (d && !f) return o ? 9 : 0;
        if (f && !d) return o ? 2 : 1;
        return 8;
    endfunction

    // Reference DFS: 0 = reached goal, 1 = exhausted, 2 = stack full.
    int mOutcome, mLen, mCur;
    logic [15:0] mMap;
    int mDirs[$];

    task automatic runModel(input logic [15:0] m0, input int depth);
        logic [15:0] m;
        int locs[$];
        int ds[$];
        int cx, cy, d, nx, ny, l;
        bit found;
        m = m0 | 16'h0001;
        cx = 0; cy = 0; d = 0;
        forever begin
            if (cx == 3 && cy == 3) begin mOutcome = 0; break; end
            found = 0;
            nx = cx; ny = cy;
            while (d < 4 && !found) begin
                nx = cx; ny = cy;
                case (d)
                    0: ny = cy - 1;
                    1: nx = cx + 1;
                    2: ny = cy + 1;
                    default: nx = cx - 1;
                endcase
                if (nx >= 0 && nx < 4 && ny >= 0 && ny < 4 && m[ny*4+nx] == 1'b0) found = 1;
                else d++;
            end
            if (found) begin
                if (locs.size() == depth) begin mOutcome = 2; break; end
                m[ny*4+nx] = 1'b1;
                locs.push_back(cy*4 + cx);
                ds.push_back(d);
                cx = nx; cy = ny; d = 0;
            end else if (locs.size() == 0) begin
                mOutcome = 1; break;
            end else begin
                l = locs.pop_back();
                d = ds.pop_back() + 1;
                cx = l % 4; cy = l / 4;
            end
        end
        mLen = locs.size();
        mCur = cy*4 + cx;
        mMap = m;
        mDirs = ds;
    endtask

    typedef struct {
        int outcome;
        int len;
        int cur;
        logic [15:0] map;
    } exp_t;
    exp_t expQ[$];
    int dirQ[$];

    task automatic scoreTerm();
        exp_t e;
        if (expQ.size() == 0) begin
            check("unexpected_term", 1, 0);
            return;
        end
        e = expQ.pop_front();
        $display("[TB] search end: outcome=%0d len=%0d cur=%0d", outcomeOf(doneA, failA, ovfA), pathLenA, curLocA);
        check("outcome", outcomeOf(doneA, failA, ovfA), e.outcome);
        check("path_len", pathLenA, e.len);
        check("cur_loc", curLocA, e.cur);
        check("map", mapA, e.map);
        check("busy_at_end", busyA, 0);
    endtask

    task automatic scoreMove();
        if (dirQ.size() == 0) check("extra_move", 1, 0);
        else check("move_dir", moveDirA, dirQ.pop_front());
    endtask

    logic prevTermA = 1'b0;
    logic prevEndA = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mapRdA && mapWrA) rdwrViol++;
            if (mapRdB && mapWrB) rdwrViol++;
            if (moveValidA) scoreMove();
            if (pathEndA) check("path_end_remaining", dirQ.size(), 0);
            if ((doneA || failA) && !prevTermA && !prevEndA) scoreTerm();
        end
        prevTermA <= doneA || failA;
        prevEndA  <= pathEndA;
    end

    task automatic loadMapA(input logic [15:0] m);
        mapInitA = m; loadA = 1'b1;
        @(negedge clk);
        loadA = 1'b0;
    endtask

    task automatic searchA(input logic [15:0] m, input bit poke, output bit ok);
        ok = 0;
        loadMapA(m);
        runModel(m, 256);
        expQ.push_back('{mOutcome, mLen, mCur, mMap});
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            startA = 1'b1;
            @(negedge clk);
            startA = 1'b0;
        end
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (doneA || failA) ok = 1;
        end
        if (!ok) begin
            check("search_timeout", 1, 0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            expQ.delete();
        end
    endtask

    task automatic doReplayA(input bit withStart);
        bit seen;
        seen = 0;
        foreach (mDirs[i]) dirQ.push_back(mDirs[i]);
        runA = 1'b1; startA = withStart;
        @(negedge clk);
        runA = 1'b0; startA = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (pathEndA) begin seen = 1; break; end
            @(negedge clk);
        end
        $display("[TB] replay of %0d moves, path_end seen=%0d", mDirs.size(), seen);
        if (!seen) begin
            check("replay_timeout", 1, 0);
            dirQ.delete();
        end
        @(negedge clk);
        check("done_after_replay", doneA, 1);
    endtask

    task automatic searchB(input logic [15:0] m);
        bit ok;
        ok = 0;
        mapInitB = m; loadB = 1'b1;
        @(negedge clk);
        loadB = 1'b0;
        runModel(m, 3);
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (doneB || failB) ok = 1;
        end
        $display("[TB] B search end: outcome=%0d len=%0d cur=%0d", outcomeOf(doneB, failB, ovfB), pathLenB, curLocB);
        if (!ok) begin
            check("B_timeout", 1, 0);
            return;
        end
        check("B_outcome", outcomeOf(doneB, failB, ovfB), mOutcome);
        check("B_path_len", pathLenB, mLen);
        check("B_cur_loc", curLocB, mCur);
        check("B_map", mapB, mMap);
    endtask

    initial begin
        bit ok;
        int nrd;
        logic [15:0] m;
        rst = 1'b1; startA = 0; runA = 0; startB = 0; runB = 0;
        loadA = 0; loadB = 0; mapInitA = '0; mapInitB = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busyA, 0);
        check("rst_done", doneA, 0);
        check("rst_fail", failA, 0);
        check("rst_overflow", ovfA, 0);
        check("rst_cur_loc", curLocA, 0);
        check("rst_path_len", pathLenA, 0);
        check("rst_strobes", {mapRdA, mapWrA, moveValidA, pathEndA}, 0);

        // Open grid, then run+start together, then a repeat replay.
        searchA(16'h0000, 0, ok);
        check("open_len_const", mLen, 6);
        if (ok && mOutcome == 0) begin
            doReplayA(0);
            doReplayA(1);
        end

        searchA(16'h0012, 0, ok);                 // walls at cells 1 and 4
        searchA(16'h0644, 1, ok);                 // walls at 2, 6, 9, 10
        if (ok && mOutcome == 0) doReplayA(0);

        // Abort a search while a read is in flight.
        loadMapA(16'h0000);
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        nrd = 0;
        for (int i = 0; i < 200 && nrd < 3; i++) begin
            @(negedge clk);
            if (mapRdA) nrd++;
        end
        check("reads_before_abort", nrd, 3);
        @(negedge clk);
        check("busy_before_abort", busyA, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busyA, 0);
        check("abort_cur_loc", curLocA, 0);
        check("abort_path_len", pathLenA, 0);
        rst = 1'b0;
        @(negedge clk);
        searchA(16'h0000, 0, ok);
        if (ok && mOutcome == 0) doReplayA(0);

        for (int t = 0; t < 24; t++) begin
            m = 16'($urandom() & $urandom()) & 16'hFFFE;
            searchA(m, 1'($urandom_range(0, 1)), ok);
            if (ok && mOutcome == 0) begin
                doReplayA(1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) doReplayA(0);
            end
        end

        // Shallow stack: the open grid runs out of entries on the fourth push.
        searchB(16'h0000);
        check("B_fail_const", failB, 1);
        check("B_overflow_const", ovfB, 1);
        check("B_len_const", pathLenB, 3);
        for (int t = 0; t < 6; t++) searchB(16'($urandom() & $urandom()) & 16'hFFFE);

        repeat (4) @(negedge clk);
        check("rd_wr_exclusive", rdwrViol, 0);
        check("scoreboard_drained", expQ.size(), 0);
        check("moves_drained", dirQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
